// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// The search helper returns {found, winner_index}.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   // Scan from the farthest offset down to last+1 so the nearest requester after 'last' wins.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] k;
      rr_pick = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         k = last + IDX_W'(i);
         if (req[k]) rr_pick = {1'b1, k};
      end
   endfunction

endpackage

// File: rtl/arb_rr_4_decoder.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module Decoder_2_4 (
   input  logic [1:0] i_idx,
   input  logic       i_en,
   output logic [3:0] o_dec
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         assign o_dec[gi] = i_en && (i_idx == 2'(gi));
      end
   endgenerate

endmodule

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with a bounded hold time per owner.
// Owner, rotation pointer and hold counter are registered; grant is decoded from the registered index.
module arb_rr_4
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   state_t           r_state;
   state_t           w_state_next;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_next;
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] w_last_next;
   logic [3:0]       r_hold_cnt;
   logic [3:0]       w_hold_cnt_next;
   logic [IDX_W:0]   w_pick;
   logic             w_arb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_last     <= IDX_W'(N_REQ - 1);
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_idx      <= w_idx_next;
         r_last     <= w_last_next;
         r_hold_cnt <= w_hold_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_idx_next      = r_idx;
      w_last_next     = r_last;
      w_hold_cnt_next = r_hold_cnt;

      w_pick = rr_pick(req, r_last);
      w_arb  = ((r_state == IDLE) && (|req)) ||
               ((r_state == BUSY) && (!req[r_idx] || (r_hold_cnt == 4'(HOLD_MAX))));

      if (w_arb) begin
         if (w_pick[IDX_W]) begin
            w_state_next    = BUSY;
            w_idx_next      = w_pick[IDX_W-1:0];
            w_last_next     = w_pick[IDX_W-1:0];
            w_hold_cnt_next = 4'd1;
         end else begin
            // Nobody asking: release, but keep the rotation pointer.
            w_state_next    = IDLE;
            w_idx_next      = '0;
            w_hold_cnt_next = '0;
         end
      end else if (r_state == BUSY) begin
         w_hold_cnt_next = r_hold_cnt + 4'd1;
      end
   end

   assign grant_idx   = r_idx;
   assign grant_valid = (r_state == BUSY);

   Decoder_2_4 u_dec (
      .i_idx (r_idx),
      .i_en  (grant_valid),
      .o_dec (grant)
   );

endmodule

// File: tb/tb_arb_rr_4.sv
// Randomised and directed bench for arb_rr_4: a per-edge reference model feeds a scoreboard
// queue that a separate monitor drains, plus directed checks of rotation, release and reset.
module tb_arb_rr_4;

   localparam int HOLD_MAX = 8;
   localparam int BOUND    = 3 * HOLD_MAX + 3;

   typedef struct packed {
      logic       v;
      logic [1:0] idx;
      logic [3:0] g;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   // Reference model state: owner -1 means nobody holds the resource.
   int m_owner = -1;
   int m_last  = 3;
   int m_cnt   = 0;
   int waits[4] = '{0, 0, 0, 0};

   arb_rr_4 #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      if (m_owner < 0) e = '0;
      else begin
         e.v   = 1'b1;
         e.idx = 2'(m_owner);
         e.g   = 4'(1 << m_owner);
      end
      return e;
   endfunction

   always @(negedge rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_cnt   = 0;
   end

   // Reference model: apply the arbitration rules at each rising edge and queue the result.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1;
         m_last  = 3;
         m_cnt   = 0;
      end else begin
         bit ev;
         ev = (m_owner < 0) ? (req != 4'b0)
                            : (!req[m_owner] || (m_cnt == HOLD_MAX));
         if (ev) begin
            m_owner = -1;
            for (int i = 1; i <= 4; i++) begin
               if (m_owner < 0 && req[(m_last + i) % 4]) m_owner = (m_last + i) % 4;
            end
            if (m_owner >= 0) begin
               m_last = m_owner;
               m_cnt  = 1;
            end else begin
               m_cnt = 0;
            end
         end else if (m_owner >= 0) begin
            m_cnt++;
         end
      end
      sb_q.push_back(model_out());
   end

   // Monitor: drain the scoreboard and check structural properties plus starvation bound.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("sb_outputs", int'({grant_valid, grant_idx, grant}), int'(e));
      end
      check("onehot", int'($countones(grant) <= 1), 1);
      check("grant_vs_idx", int'(grant), grant_valid ? (1 << grant_idx) : 0);
      for (int k = 0; k < 4; k++) begin
         if (rst_n && req[k] && !(grant_valid && grant_idx == 2'(k))) waits[k]++;
         else waits[k] = 0;
         if (req[k]) check($sformatf("starve_%0d", k), int'(waits[k] <= BOUND), 1);
      end
   end

   task automatic step(input logic [3:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;

      // Reset held with all requesting: nothing granted.
      rst_n = 1'b0;
      repeat (3) step(4'b1111);
      check("reset_valid", int'(grant_valid), 0);
      check("reset_grant", int'(grant), 0);
      check("reset_idx", int'(grant_idx), 0);

      // Release: first edge grants 0, then 0,1,2,3,0 each for HOLD_MAX cycles.
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1111;
      @(posedge clk);
      #2;
      check("first_grant", int'(grant), 1);
      for (int c = 1; c <= 4 * HOLD_MAX; c++) begin
         step(4'b1111);
         check($sformatf("rotate_c%0d", c), int'(grant_idx), (c / HOLD_MAX) % 4);
         check("rotate_valid", int'(grant_valid), 1);
      end

      // Owner 2 drops with 0 and 3 waiting: 3 wins next edge.
      step(4'b0000);
      step(4'b0100);
      check("own2", int'(grant), 4'b0100);
      step(4'b1001);
      check("drop_to_3", int'(grant), 4'b1000);
      step(4'b0100);
      check("own2_again", int'(grant), 4'b0100);
      step(4'b0000);
      check("drop_to_idle", int'(grant_valid), 0);

      // Lone requester keeps the grant across forced rotations.
      for (int c = 0; c < 20; c++) begin
         step(4'b0010);
         check($sformatf("lone1_c%0d", c), int'(grant), 4'b0010);
      end

      // Asynchronous reset in the middle of a grant.
      step(4'b0000);
      step(4'b0100);
      check("pre_async", int'(grant), 4'b0100);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_grant", int'(grant), 0);
      check("async_valid", int'(grant_valid), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0100;
      @(posedge clk);
      #2;
      check("post_async", int'(grant), 4'b0100);

      // Random request stream; each bit toggles with probability 1/8 per cycle.
      r = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
         end
         step(r);
      end

      step(4'b0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
